// File: rtl/shift_register_pkg.sv
// Shared encodings for the universal shift register: operation codes,
// shift directions and burst FSM states.
package shift_register_pkg;

  localparam logic [2:0] MODO_SHIFT = 3'b000;
  localparam logic [2:0] MODO_ROT   = 3'b001;
  localparam logic [2:0] MODO_LOAD  = 3'b010;
  localparam logic [2:0] MODO_CLR   = 3'b011;
  localparam logic [2:0] MODO_ASH   = 3'b100;
  localparam logic [2:0] MODO_HOLD  = 3'b101;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Only the three bit-moving operations can be repeated by the burst engine.
  function automatic logic is_burst_op(input logic [2:0] op);
    return (op == MODO_SHIFT) || (op == MODO_ROT) || (op == MODO_ASH);
  endfunction

endpackage

// File: rtl/shift_next_value.sv
// Combinational next-state for the register contents and serial output,
// shared by single-step operation and the burst engine.
module shift_next_value
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic             dir,
  input  logic [WIDTH-1:0] q,
  input  logic             s_out,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             s_out_next
);

  always_comb begin
    q_next     = q;
    s_out_next = s_out;
    case (op)
      MODO_SHIFT: begin
        if (dir == DIR_RIGHT) begin
          q_next     = {s_in, q[WIDTH-1:1]};
          s_out_next = q[0];
        end else begin
          q_next     = {q[WIDTH-2:0], s_in};
          s_out_next = q[WIDTH-1];
        end
      end
      MODO_ROT: begin
        if (dir == DIR_RIGHT) begin
          q_next     = {q[0], q[WIDTH-1:1]};
          s_out_next = q[0];
        end else begin
          q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
          s_out_next = q[WIDTH-1];
        end
      end
      MODO_ASH: begin
        // Right shift replicates the sign bit; left shift fills with zero.
        if (dir == DIR_RIGHT) begin
          q_next     = {q[WIDTH-1], q[WIDTH-1:1]};
          s_out_next = q[0];
        end else begin
          q_next     = {q[WIDTH-2:0], 1'b0};
          s_out_next = q[WIDTH-1];
        end
      end
      MODO_LOAD: q_next = d;
      MODO_CLR: begin
        q_next     = '0;
        s_out_next = 1'b0;
      end
      default: begin
        q_next     = q;
        s_out_next = s_out;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register_seq.sv
// Universal shift register with single-step operations and an automatic
// burst engine that repeats a shift/rotate AMT times unattended.
module universal_shift_register_seq
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [2:0]       MODO,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             fsm_state
);

  // Burst handshake: START is a request level sampled only in IDLE on an
  // enabled edge; acceptance raises BUSY on that edge, and completion drops
  // BUSY while DONE pulses high for one cycle. An abort or reset drops BUSY
  // with no DONE. AMT=0 completes at once: DONE pulses, BUSY never rises.
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_l;
  logic             dir_l;
  logic [2:0]       op_sel;
  logic             dir_sel;
  logic [WIDTH-1:0] q_next;
  logic             s_out_next;

  assign fsm_state = state[0];
  assign op_sel    = (state == ST_RUN) ? op_l  : MODO;
  assign dir_sel   = (state == ST_RUN) ? dir_l : DIR;

  shift_next_value #(.WIDTH(WIDTH)) u_next (
    .op         (op_sel),
    .dir        (dir_sel),
    .q          (Q),
    .s_out      (S_OUT),
    .s_in       (S_IN),
    .d          (D),
    .q_next     (q_next),
    .s_out_next (s_out_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q     <= '0;
      S_OUT <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      cnt   <= '0;
      op_l  <= MODO_SHIFT;
      dir_l <= DIR_LEFT;
      state <= ST_IDLE;
    end else if (!ENB) begin
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START && is_burst_op(MODO)) begin
            if (AMT != '0) begin
              op_l  <= MODO;
              dir_l <= DIR;
              cnt   <= AMT;
              BUSY  <= 1'b1;
              state <= ST_RUN;
            end else begin
              DONE <= 1'b1;
            end
          end else begin
            Q     <= q_next;
            S_OUT <= s_out_next;
          end
        end
        ST_RUN: begin
          // Clear is the only live command during a burst and acts as abort.
          if (MODO == MODO_CLR) begin
            Q     <= '0;
            S_OUT <= 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            Q     <= q_next;
            S_OUT <= s_out_next;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Bench for universal_shift_register_seq: directed scenarios plus random
// traffic, checked cycle by cycle against an arithmetic reference model.
module tb_universal_shift_register_seq;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK;
  logic          RESET;
  logic          ENB;
  logic [2:0]    MODO;
  logic          DIR;
  logic          S_IN;
  logic [W-1:0]  D;
  logic          START;
  logic [CW-1:0] AMT;
  logic [W-1:0]  Q;
  logic          S_OUT;
  logic          BUSY;
  logic          DONE;
  logic          fsm_state;

  universal_shift_register_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENB       (ENB),
    .MODO      (MODO),
    .DIR       (DIR),
    .S_IN      (S_IN),
    .D         (D),
    .START     (START),
    .AMT       (AMT),
    .Q         (Q),
    .S_OUT     (S_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: register value as an integer, burst as a remaining count
  logic [W-1:0]  m_q;
  logic          m_s;
  logic          m_busy;
  logic          m_done;
  int            m_left;
  logic [2:0]    m_op;
  logic          m_dir;
  logic [W+2:0]  exp_q[$];

  function automatic void model_apply(input logic [2:0] op, input logic dr, input logic si,
                                      input logic [W-1:0] dd);
    int unsigned qi;
    qi = int'(m_q);
    case (op)
      3'd0: if (!dr) begin m_s = 1'(qi / 128); m_q = W'((qi * 2) % 256 + si); end
            else     begin m_s = 1'(qi % 2);   m_q = W'(qi / 2 + si * 128); end
      3'd1: if (!dr) begin m_s = 1'(qi / 128); m_q = W'((qi * 2) % 256 + qi / 128); end
            else     begin m_s = 1'(qi % 2);   m_q = W'(qi / 2 + (qi % 2) * 128); end
      3'd4: if (!dr) begin m_s = 1'(qi / 128); m_q = W'((qi * 2) % 256); end
            else     begin m_s = 1'(qi % 2);   m_q = W'(qi / 2 + (qi / 128) * 128); end
      3'd2: m_q = dd;
      3'd3: begin m_q = '0; m_s = 1'b0; end
      default: ;
    endcase
  endfunction

  function automatic void model_step();
    if (RESET) begin
      m_q = '0; m_s = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (!ENB) begin
      m_done = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (START && (MODO == 3'd0 || MODO == 3'd1 || MODO == 3'd4)) begin
        if (AMT != 0) begin
          m_busy = 1'b1; m_left = int'(AMT); m_op = MODO; m_dir = DIR;
        end else begin
          m_done = 1'b1;
        end
      end else begin
        model_apply(MODO, DIR, S_IN, D);
      end
    end else if (MODO == 3'd3) begin
      m_q = '0; m_s = 1'b0; m_busy = 1'b0; m_left = 0; m_done = 1'b0;
    end else begin
      model_apply(m_op, m_dir, S_IN, D);
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endfunction

  // one clock: model advances on the edge, DUT is sampled 1 time unit later
  task automatic tick();
    logic [W+2:0] e;
    @(posedge CLK);
    model_step();
    exp_q.push_back({m_done, m_busy, m_s, m_q});
    #1;
    e = exp_q.pop_front();
    check("q",     32'(Q),         32'(e[W-1:0]));
    check("s_out", 32'(S_OUT),     32'(e[W]));
    check("busy",  32'(BUSY),      32'(e[W+1]));
    check("done",  32'(DONE),      32'(e[W+2]));
    check("state", 32'(fsm_state), 32'(e[W+1]));
  endtask

  // driver
  task automatic drive(input logic rst, input logic en, input logic [2:0] m, input logic dr,
                       input logic si, input logic [W-1:0] dd, input logic st,
                       input logic [CW-1:0] am);
    RESET = rst; ENB = en; MODO = m; DIR = dr; S_IN = si; D = dd; START = st; AMT = am;
    tick();
  endtask

  task automatic load(input logic [W-1:0] v);
    drive(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, v, 1'b0, '0);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    RESET = 1'b1; ENB = 1'b0; MODO = 3'b000; DIR = 1'b0; S_IN = 1'b0;
    D = '0; START = 1'b0; AMT = '0;
    m_q = '0; m_s = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    m_op = 3'd0; m_dir = 1'b0;

    // 1: reset overrides ENB=0
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t1_q", 32'(Q), 32'h0);
    check("t1_s_out", 32'(S_OUT), 32'h0);
    check("t1_busy", 32'(BUSY), 32'h0);
    check("t1_done", 32'(DONE), 32'h0);

    // 2: load then rotate left
    load(8'hA5);
    drive(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t2_q", 32'(Q), 32'h4B);
    check("t2_s_out", 32'(S_OUT), 32'h1);

    // 3: arithmetic right burst of 3
    load(8'h90);
    drive(1'b0, 1'b1, 3'b100, 1'b1, 1'b0, '0, 1'b1, 4'd3);
    check("t3_accept_busy", 32'(BUSY), 32'h1);
    check("t3_accept_q", 32'(Q), 32'h90);
    idle_hold(2);
    check("t3_mid_busy", 32'(BUSY), 32'h1);
    idle_hold(1);
    check("t3_q", 32'(Q), 32'hF2);
    check("t3_s_out", 32'(S_OUT), 32'h0);
    check("t3_done", 32'(DONE), 32'h1);
    check("t3_busy_end", 32'(BUSY), 32'h0);
    idle_hold(1);
    check("t3_done_pulse", 32'(DONE), 32'h0);

    // 4: logical left burst of 4 with a two-cycle stall
    load(8'h0F);
    drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, '0, 1'b1, 4'd4);
    drive(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    drive(1'b0, 1'b0, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    drive(1'b0, 1'b0, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    check("t4_no_early_done", 32'(DONE), 32'h0);
    check("t4_stall_busy", 32'(BUSY), 32'h1);
    drive(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, '0, 1'b0, '0);
    check("t4_q", 32'(Q), 32'hFF);
    check("t4_s_out", 32'(S_OUT), 32'h0);
    check("t4_done", 32'(DONE), 32'h1);

    // 5: rotate right burst of 7 aborted on the third RUN cycle
    load(8'h81);
    drive(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, '0, 1'b1, 4'd7);
    idle_hold(2);
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t5_q", 32'(Q), 32'h0);
    check("t5_busy", 32'(BUSY), 32'h0);
    for (int i = 0; i < 8; i++) begin
      idle_hold(1);
      check("t5_no_done", 32'(DONE), 32'h0);
    end

    // 6: zero-length burst, then START with a non-burst mode
    load(8'h5A);
    drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, '0, 1'b1, 4'd0);
    check("t6_done", 32'(DONE), 32'h1);
    check("t6_q", 32'(Q), 32'h5A);
    check("t6_busy", 32'(BUSY), 32'h0);
    drive(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 8'h3C, 1'b1, 4'd5);
    check("t6_load_q", 32'(Q), 32'h3C);
    check("t6_load_busy", 32'(BUSY), 32'h0);
    check("t6_done_gone", 32'(DONE), 32'h0);

    // random traffic, abort (011) kept rare so bursts usually complete
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 7));
      if (m == 3'b011 && $urandom_range(0, 3) != 0) m = 3'b101;
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85), m,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 99) < 25), CW'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
